sap1_controller: RTL and testbench
==================================

# sap1_controller

Fetch/execute controller for the SAP-1 datapath. It is the initiator side of the 16x8 program ROM's read port: it drives read enable and read address, consumes the ROM's registered data one cycle later, and executes LDA/ADD/SUB/OUT/HLT. It owns the program counter, instruction register, accumulator, carry flag and output register, and sits between the ROM and the board-level output display.

## Interface
- DATA_WIDTH, 8, ROM word and accumulator width
- ADDRESS_SIZE, 4, ROM address width and program counter width

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_read_enable  output  1  read strobe to the ROM's readEnable
- mem_read_address  output  ADDRESS_SIZE  to the ROM's readAddress
- mem_data_in  input  DATA_WIDTH  from the ROM's dataOut; valid the cycle after a strobed read
- out_data  output  DATA_WIDTH  output register, written by OUT
- out_valid  output  1  one-cycle pulse when out_data is updated
- acc  output  DATA_WIDTH  accumulator (debug/display)
- carry  output  1  carry from last ADD / borrow from last SUB
- halted  output  1  high once HLT has executed

## Operation
- Opcodes are IR[7:4]: LDA 0000, ADD 0001, SUB 0010, OUT 1110, HLT 1111. Operand address is IR[3:0].
- The FSM states are T1 (FETCH_REQ), T2 (FETCH_CAP), T3 (EXEC_REQ), T4 (EXEC_CAP) and HALT.
- T1: mem_read_enable=1, mem_read_address=pc. Next state is T2.
- T2: mem_read_enable=0. At the clock edge ending T2: ir<=mem_data_in and pc<=pc+1, wrapping mod 16 (15->0). Next state is T3.
- T3 actions by opcode:
  - LDA/ADD/SUB: mem_read_enable=1, mem_read_address=ir[3:0]. Next state is T4.
  - OUT: out_data<=acc at the edge ending T3. Next state is T1.
  - HLT: next state is HALT.
  - Any other opcode: NOP. Next state is T1.
- T4 actions by opcode:
  - LDA: acc<=mem_data_in. Carry is unchanged.
  - ADD: {carry,acc}<=acc+mem_data_in, 9-bit sum with the low 8 bits kept.
  - SUB: acc<=acc-mem_data_in mod 256; carry<=1 iff mem_data_in>acc (borrow).
  - Next state is T1.
- HALT: no reads, and no register changes until rst. halted=1 in HALT.
- mem_read_enable is high only in T1 and in T3 for LDA/ADD/SUB.
- mem_read_address is driven combinationally from the state and pc/ir, and is 0 when mem_read_enable=0.

## Timing
- Reset values: pc=0, ir=0, acc=0, carry=0, out_data=0, out_valid=0, halted=0, state=T1.
- After rst deasserts, the first rising edge already sits in T1 with mem_read_enable=1 and address 0.
- Instruction length is 4 cycles for LDA/ADD/SUB and 3 cycles for OUT/NOP. HLT takes 3 cycles to reach HALT.
- ROM read latency is exactly 1 cycle. The controller never issues reads on back-to-back cycles.
- out_valid is high for exactly the one cycle after the edge that loads out_data. It is never high during HALT except on that cycle.
- halted rises in the cycle after T3 of HLT and stays high until rst.
- rst asserted mid-instruction immediately forces all reset values; no partial result is committed.
- pc wrapping 15->0 is silent, with no flag.

## Structure
- sap1_pkg holds:
  - the opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - the state encodings T1..T4 and HALT
  - the DATA_WIDTH/ADDRESS_SIZE defaults
- sap1_alu is one sub-module: combinational add/sub with a 9-bit result and carry/borrow. It is instantiated once; the controller registers its outputs in T4.
- The top-level ties the controller to memory_16x8_rom (clk, readEnable, readAddress, dataOut).

## Test plan
- Reset then release, with a model ROM holding the default program -> out_valid pulses carry, in order: 0x01, 0x03, 0x06, 0x02, 0x02. Then LDA 1..4 load acc with 0xEF, 0x1A, 0xEF, 0x1B. The 0xFF at address 13 halts: halted=1, pc=14, no further reads.
- Cycle check on LDA 9 from reset:
  - read at address 0 in T1 and at address 9 in T3;
  - acc=0x01 after the 4th edge;
  - mem_read_enable is never high on two consecutive cycles.
- Arithmetic boundaries:
  - acc=0xFF, ADD 0x01 -> acc=0x00, carry=1.
  - acc=0x02, SUB 0x04 -> acc=0xFE, carry=1.
  - acc=0x05, SUB 0x05 -> acc=0x00, carry=0.
- PC wrap: a ROM of all NOPs (0x30) -> pc cycles 0..15 then 0 with 3-cycle spacing; acc and out_data stay 0.
- Reset mid-operation: assert rst during T4 of ADD -> acc, pc and carry are 0 immediately, and the fetch restarts from address 0 after release.
- Reset out of HALT: apply rst while halted -> halted=0 and execution restarts at pc 0.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller: datapath widths, opcode values
// and the fetch/execute state encoding.
package sap1_pkg;

    localparam int SAP1_DATA_WIDTH   = 8;
    localparam int SAP1_ADDRESS_SIZE = 4;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        HALT = 3'd4
    } state_t;

endpackage

// File: rtl/sap1_alu.sv
// Combinational SAP-1 adder/subtractor. The extra result bit is the carry on
// add and the borrow on subtract.
module sap1_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);

    logic [DATA_WIDTH:0] wide;

    // Zero-extending both operands makes the top bit of a-b the borrow (b > a).
    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = wide[DATA_WIDTH-1:0];
    assign carry  = wide[DATA_WIDTH];

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 fetch/execute controller: drives the program ROM read port, holds
// pc/ir/acc/carry/out registers and executes LDA, ADD, SUB, OUT and HLT.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int DATA_WIDTH   = SAP1_DATA_WIDTH,
    parameter int ADDRESS_SIZE = SAP1_ADDRESS_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_read_enable,
    output logic [ADDRESS_SIZE-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   acc,
    output logic                    carry,
    output logic                    halted
);

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [DATA_WIDTH-1:0]   ir;
    logic [3:0]              opcode;
    logic                    mem_op;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_carry;

    assign opcode = ir[DATA_WIDTH-1 -: 4];
    assign mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

    sap1_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a      (acc),
        .b      (mem_data_in),
        .sub    (opcode == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        mem_read_enable  = 1'b0;
        mem_read_address = '0;
        case (state)
            T1: begin
                mem_read_enable  = 1'b1;
                mem_read_address = pc;
            end
            T3: begin
                if (mem_op) begin
                    mem_read_enable  = 1'b1;
                    mem_read_address = ir[ADDRESS_SIZE-1:0];
                end
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= T1;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                T1: state <= T2;
                T2: begin
                    ir    <= mem_data_in;
                    pc    <= pc + ADDRESS_SIZE'(1);
                    state <= T3;
                end
                T3: begin
                    if (mem_op) begin
                        state <= T4;
                    end else if (opcode == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                        state     <= T1;
                    end else if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= T1;
                    end
                end
                T4: begin
                    // mem_data_in now holds the operand read issued in T3.
                    if (opcode == OP_LDA) begin
                        acc <= mem_data_in;
                    end else begin
                        acc   <= alu_result;
                        carry <= alu_carry;
                    end
                    state <= T1;
                end
                HALT:    state <= HALT;
                default: state <= T1;
            endcase
        end
    end

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller with a registered 16x8 ROM model and
// an instruction-level reference model of the SAP-1 ISA.
module tb_sap1_controller;

    logic       clk;
    logic       rst;
    logic       mem_read_enable;
    logic [3:0] mem_read_address;
    logic [7:0] mem_data_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic [7:0] acc;
    logic       carry;
    logic       halted;

    sap1_controller dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_enable  (mem_read_enable),
        .mem_read_address (mem_read_address),
        .mem_data_in      (mem_data_in),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .acc              (acc),
        .carry            (carry),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM: data appears the cycle after a strobed read.
    logic [7:0] rom [16];
    always @(posedge clk) begin
        if (mem_read_enable) mem_data_in <= rom[mem_read_address];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: observed outputs, accumulator history, read-protocol violations.
    logic [7:0] obs_q[$];
    logic [7:0] acc_hist[$];
    logic [7:0] prev_acc = 8'h00;
    logic       prev_en  = 1'b0;
    int         b2b_reads  = 0;
    int         halt_reads = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) obs_q.push_back(out_data);
            if (acc != prev_acc) acc_hist.push_back(acc);
            if (mem_read_enable && prev_en) b2b_reads++;
            if (halted && mem_read_enable) halt_reads++;
        end
        prev_acc = acc;
        prev_en  = rst ? 1'b0 : mem_read_enable;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        obs_q.delete();
        acc_hist.delete();
        b2b_reads  = 0;
        halt_reads = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step(1);
            n++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    // Instruction-level reference: each instruction is an ISA step plus its
    // documented cycle cost (4 for memory operations, 3 otherwise).
    int         m_cycles;
    logic [7:0] m_acc;
    logic       m_carry;
    logic       m_halt;
    logic [3:0] m_pc;
    logic [7:0] exp_q[$];

    task automatic run_model(input int max_instr);
        logic [7:0] instr;
        logic [7:0] opnd;
        int         sum;
        m_cycles = 0; m_acc = 8'h00; m_carry = 1'b0; m_halt = 1'b0; m_pc = 4'd0;
        exp_q.delete();
        for (int n = 0; n < max_instr && !m_halt; n++) begin
            instr = rom[m_pc];
            m_pc  = m_pc + 4'd1;
            opnd  = rom[instr[3:0]];
            case (instr[7:4])
                4'h0: begin m_acc = opnd; m_cycles += 4; end
                4'h1: begin
                    sum     = int'(m_acc) + int'(opnd);
                    m_carry = (sum > 255);
                    m_acc   = 8'(sum);
                    m_cycles += 4;
                end
                4'h2: begin
                    m_carry = (opnd > m_acc);
                    sum     = int'(m_acc) - int'(opnd) + 256;
                    m_acc   = 8'(sum);
                    m_cycles += 4;
                end
                4'hE: begin exp_q.push_back(m_acc); m_cycles += 3; end
                4'hF: begin m_halt = 1'b1; m_cycles += 3; end
                default: m_cycles += 3;
            endcase
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_acc;
        logic       exp_carry;
    } alu_vec_t;

    alu_vec_t   vecs [7];
    logic [7:0] exp_out  [5] = '{8'h01, 8'h03, 8'h06, 8'h02, 8'h02};
    logic [7:0] exp_accs [8] = '{8'h01, 8'h03, 8'h06, 8'h02, 8'hEF, 8'h1A, 8'hEF, 8'h1B};

    initial begin
        rst = 1'b1;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{8'h02, 8'h04, 1'b1, 8'hFE, 1'b1};
        vecs[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h7E, 1'b0};

        rom = '{8'h09, 8'hEF, 8'h1A, 8'hEF, 8'h1B, 8'hEF, 8'h2C, 8'hEF,
                8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00, 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_acc", acc, 8'h00);
        check("rst_carry", carry, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_read_en", mem_read_enable, 1'b1);
        check("rst_read_addr", mem_read_address, 4'd0);

        // LDA 9 cycle-by-cycle
        do_reset();
        #1;
        check("lda_t1_en", mem_read_enable, 1'b1);
        check("lda_t1_addr", mem_read_address, 4'd0);
        step(1);
        check("lda_t2_en", mem_read_enable, 1'b0);
        step(1);
        check("lda_t3_en", mem_read_enable, 1'b1);
        check("lda_t3_addr", mem_read_address, 4'd9);
        step(1);
        check("lda_t4_en", mem_read_enable, 1'b0);
        check("lda_t4_acc_old", acc, 8'h00);
        step(1);
        check("lda_acc", acc, 8'h01);
        check("lda_next_addr", mem_read_address, 4'd1);

        // Default program to completion
        wait_halt(200);
        check("dflt_out_count", obs_q.size(), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) check($sformatf("dflt_out%0d", i), obs_q[i], exp_out[i]);
        check("dflt_acc_count", acc_hist.size(), 8);
        for (int i = 0; i < 8 && i < acc_hist.size(); i++) check($sformatf("dflt_acc%0d", i), acc_hist[i], exp_accs[i]);
        check("dflt_pc", dut.pc, 4'd14);
        check("dflt_carry", carry, 1'b0);
        step(20);
        check("halt_no_reads", halt_reads, 0);
        check("halt_stays", halted, 1'b1);
        check("halt_out_valid", out_valid, 1'b0);
        check("halt_acc_held", acc, 8'h1B);
        check("no_b2b_reads", b2b_reads, 0);

        // Reset out of HALT
        #2 rst = 1'b1;
        #1;
        check("hrst_halted", halted, 1'b0);
        check("hrst_addr", mem_read_address, 4'd0);
        check("hrst_en", mem_read_enable, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        step(4);
        check("hrst_restart_acc", acc, 8'h01);
        check("hrst_restart_addr", mem_read_address, 4'd1);

        // Arithmetic table: LDA 14, ADD/SUB 15, HLT
        for (int v = 0; v < 7; v++) begin
            foreach (rom[i]) rom[i] = 8'h00;
            rom[0]  = 8'h0E;
            rom[1]  = vecs[v].sub ? 8'h2F : 8'h1F;
            rom[2]  = 8'hF0;
            rom[14] = vecs[v].a;
            rom[15] = vecs[v].b;
            do_reset();
            wait_halt(30);
            check($sformatf("alu%0d_acc", v), acc, vecs[v].exp_acc);
            check($sformatf("alu%0d_carry", v), carry, vecs[v].exp_carry);
        end

        // PC wrap with all NOPs
        foreach (rom[i]) rom[i] = 8'h30;
        do_reset();
        #1;
        check("wrap_k0", {mem_read_enable, mem_read_address}, 5'h10);
        for (int k = 1; k < 18; k++) begin
            step(3);
            check($sformatf("wrap_k%0d", k), {mem_read_enable, mem_read_address}, {1'b1, 4'(k % 16)});
        end
        check("wrap_acc", acc, 8'h00);
        check("wrap_out_data", out_data, 8'h00);
        check("wrap_no_out", obs_q.size(), 0);

        // Reset during T4 of ADD
        foreach (rom[i]) rom[i] = 8'h00;
        rom[0] = 8'h0E; rom[1] = 8'h1F; rom[2] = 8'hF0;
        rom[14] = 8'hFF; rom[15] = 8'h01;
        do_reset();
        step(7);
        check("mid_pre_acc", acc, 8'hFF);
        #2 rst = 1'b1;
        #1;
        check("mid_acc", acc, 8'h00);
        check("mid_carry", carry, 1'b0);
        check("mid_pc", dut.pc, 4'd0);
        check("mid_addr", {mem_read_enable, mem_read_address}, 5'h10);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        step(4);
        check("mid_restart_acc", acc, 8'hFF);
        check("mid_restart_addr", mem_read_address, 4'd1);
        check("mid_restart_carry", carry, 1'b0);
        wait_halt(30);
        check("mid_final_acc", acc, 8'h00);
        check("mid_final_carry", carry, 1'b1);

        // Random programs against the ISA model
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                case ($urandom_range(0, 11))
                    0, 1:    op = 4'h0;
                    2, 3:    op = 4'h1;
                    4, 5:    op = 4'h2;
                    6, 7:    op = 4'hE;
                    8:       op = 4'hF;
                    default: op = 4'($urandom_range(3, 13));
                endcase
                rom[i] = {op, 4'($urandom_range(0, 15))};
            end
            run_model(24);
            do_reset();
            step(m_cycles);
            check($sformatf("rnd%0d_out_count", p), obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                check($sformatf("rnd%0d_out%0d", p, i), obs_q[i], exp_q[i]);
            check($sformatf("rnd%0d_acc", p), acc, m_acc);
            check($sformatf("rnd%0d_carry", p), carry, m_carry);
            check($sformatf("rnd%0d_halted", p), halted, m_halt);
            check($sformatf("rnd%0d_pc", p), dut.pc, m_pc);
            if (!m_halt) check($sformatf("rnd%0d_fetch", p), {mem_read_enable, mem_read_address}, {1'b1, m_pc});
            check($sformatf("rnd%0d_b2b", p), b2b_reads, 0);
            check($sformatf("rnd%0d_halt_reads", p), halt_reads, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
